// File: rtl/matrix_slot_store.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matrix_slot_store: slot-managed 512x32 matrix RAM with per-slot directory,
// allocation victim scan and (m,n,ordinal) lookup. Optional: MATSTORE_GUARD_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
module matrix_slot_store #(
  parameter int NUM_SLOTS   = 20,
  parameter int SLOT_WORDS  = 25,
  parameter int MAX_PER_DIM = 2,
  parameter int DEPTH       = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_req,
  input  logic [2:0]  alloc_m,
  input  logic [2:0]  alloc_n,
  output logic        addr_ready,
  output logic [8:0]  base_addr,
  input  logic        commit,
  input  logic        abort,
  input  logic        wr_en,
  input  logic [8:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [8:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        q_req,
  input  logic [2:0]  q_m,
  input  logic [2:0]  q_n,
  input  logic [2:0]  q_idx,
  output logic        q_done,
  output logic        q_found,
  output logic [8:0]  q_base,
  output logic [2:0]  q_count,
  output logic        busy,
  output logic        wr_err
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IW-1:0] LAST  = IW'(NUM_SLOTS - 1);
  localparam logic [9:0]    LIMIT = 10'(NUM_SLOTS * SLOT_WORDS);

  typedef enum logic [2:0] {IDLE, ASCAN, GRANT, FILL, QSCAN, QDONE} state_t;
  state_t state, state_next;

  logic [NUM_SLOTS-1:0] valid;
  logic [2:0]  dir_m [NUM_SLOTS];
  logic [2:0]  dir_n [NUM_SLOTS];
  logic [7:0]  stamp [NUM_SLOTS];
  logic [7:0]  alloc_cnt;
  logic [IW-1:0] scan_idx, victim, victim_sel;
  logic [2:0]  req_m, req_n, cur_m, cur_n, qm, qn, qidx;
  logic        pending;
  logic [7:0]  match_cnt, match_age, old_age, q_cnt;
  logic [IW-1:0] match_idx, free_idx, old_idx;
  logic        free_found, old_found, q_hit;
  logic [8:0]  q_hit_base;
  logic [31:0] mem [DEPTH];

  logic s_valid, s_match_a, s_match_q, accept_alloc, accept_q, fill_commit, fill_close;
  logic [7:0] s_age;
  logic in_range, wr_ok;

  function automatic logic [8:0] slot_base(input logic [IW-1:0] idx);
    return 9'(idx) * 9'(SLOT_WORDS);
  endfunction

  always_comb begin
    s_valid      = valid[scan_idx];
    s_age        = alloc_cnt - stamp[scan_idx];
    s_match_a    = s_valid && dir_m[scan_idx] == req_m && dir_n[scan_idx] == req_n;
    s_match_q    = s_valid && dir_m[scan_idx] == qm && dir_n[scan_idx] == qn;
    accept_alloc = (state == IDLE || state == FILL) && alloc_req;
    accept_q     = (state == IDLE || state == FILL) && !alloc_req && q_req;
    // alloc_req during FILL closes the pending slot as an implicit commit
    fill_close   = state == FILL && (commit || abort || alloc_req);
    fill_commit  = fill_close && !abort;
    if (match_cnt >= 8'(MAX_PER_DIM)) victim_sel = match_idx;
    else if (free_found)              victim_sel = free_idx;
    else                              victim_sel = old_idx;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (alloc_req) state_next = ASCAN;
             else if (q_req) state_next = QSCAN;
      ASCAN: if (scan_idx == LAST) state_next = GRANT;
      GRANT: state_next = FILL;
      FILL:  if (alloc_req) state_next = ASCAN;
             else if (q_req) state_next = QSCAN;
             else if (commit || abort) state_next = IDLE;
      QSCAN: if (scan_idx == LAST) state_next = QDONE;
      QDONE: state_next = pending ? FILL : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign busy = (state != IDLE) && (state != FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      alloc_cnt  <= '0;
      addr_ready <= 1'b0;
      base_addr  <= '0;
      q_done     <= 1'b0;
      q_found    <= 1'b0;
      q_base     <= '0;
      q_count    <= '0;
      pending    <= 1'b0;
      scan_idx   <= '0;
      victim     <= '0;
      cur_m      <= '0;
      cur_n      <= '0;
    end else begin
      addr_ready <= 1'b0;
      q_done     <= 1'b0;
      if (accept_alloc) begin
        req_m      <= alloc_m;
        req_n      <= alloc_n;
        scan_idx   <= '0;
        match_cnt  <= '0;
        free_found <= 1'b0;
        old_found  <= 1'b0;
      end else if (accept_q) begin
        qm         <= q_m;
        qn         <= q_n;
        qidx       <= q_idx;
        scan_idx   <= '0;
        q_cnt      <= '0;
        q_hit      <= 1'b0;
        q_hit_base <= '0;
      end
      if (fill_commit) begin
        valid[victim] <= 1'b1;
        dir_m[victim] <= cur_m;
        dir_n[victim] <= cur_n;
        stamp[victim] <= alloc_cnt;
        alloc_cnt     <= alloc_cnt + 8'd1;
      end
      if (fill_close) pending <= 1'b0;
      case (state)
        ASCAN: begin
          // strict '>' keeps the lower index on equal ages
          if (s_match_a) begin
            match_cnt <= match_cnt + 8'd1;
            if (match_cnt == 8'd0 || s_age > match_age) begin
              match_idx <= scan_idx;
              match_age <= s_age;
            end
          end
          if (!s_valid && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (s_valid && (!old_found || s_age > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= scan_idx;
            old_age   <= s_age;
          end
          scan_idx <= scan_idx + 1'b1;
        end
        GRANT: begin
          addr_ready        <= 1'b1;
          base_addr         <= slot_base(victim_sel);
          victim            <= victim_sel;
          valid[victim_sel] <= 1'b0;
          cur_m             <= req_m;
          cur_n             <= req_n;
          pending           <= 1'b1;
        end
        QSCAN: begin
          if (s_match_q) begin
            if (q_cnt == {5'b0, qidx}) begin
              q_hit      <= 1'b1;
              q_hit_base <= slot_base(scan_idx);
            end
            q_cnt <= q_cnt + 8'd1;
          end
          scan_idx <= scan_idx + 1'b1;
        end
        QDONE: begin
          q_done  <= 1'b1;
          q_found <= q_hit;
          q_base  <= q_hit ? q_hit_base : 9'd0;
          q_count <= (q_cnt > 8'd7) ? 3'd7 : q_cnt[2:0];
        end
        default: ;
      endcase
    end
  end

  assign in_range = {1'b0, wr_addr} < LIMIT;

`ifdef MATSTORE_GUARD_EN
  logic [5:0] slot_area;
  logic [9:0] slot_end;
  assign slot_area = 6'(cur_m) * 6'(cur_n);
  assign slot_end  = {1'b0, base_addr} + {4'b0, slot_area};
  assign wr_ok = wr_en && in_range && state == FILL &&
                 wr_addr >= base_addr && {1'b0, wr_addr} < slot_end;

  always_ff @(posedge clk) begin
    if (rst)                  wr_err <= 1'b0;
    else if (wr_en && !wr_ok) wr_err <= 1'b1;
    else if (state == GRANT)  wr_err <= 1'b0;
  end
`else
  assign wr_ok  = wr_en && in_range;
  assign wr_err = 1'b0;
`endif

  // RAM array kept free of reset so it maps to block memory
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_slot_store.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_matrix_slot_store: scoreboard bench for grants, lookups and RAM access.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_matrix_slot_store;

  localparam int NUM_SLOTS = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req, commit, abort, wr_en, q_req;
  logic [2:0]  alloc_m, alloc_n, q_m, q_n, q_idx;
  logic [8:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic        addr_ready, q_done, q_found, busy, wr_err;
  logic [8:0]  base_addr, q_base;
  logic [31:0] rd_data;
  logic [2:0]  q_count;

  matrix_slot_store dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
    .addr_ready(addr_ready), .base_addr(base_addr),
    .commit(commit), .abort(abort),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .q_req(q_req), .q_m(q_m), .q_n(q_n), .q_idx(q_idx),
    .q_done(q_done), .q_found(q_found), .q_base(q_base), .q_count(q_count),
    .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       found;
    logic [8:0] base;
    logic [2:0] count;
  } qexp_t;

  logic [8:0] a_sb [$];
  qexp_t      q_sb [$];
  int checks   = 0;
  int failures = 0;
  logic [8:0] a_e;
  qexp_t      q_e;
  logic [31:0] rdv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && addr_ready) begin
      if (a_sb.size() == 0) check("grant_unexpected", 1, 0);
      else begin
        a_e = a_sb.pop_front();
        check("base_addr", 32'(base_addr), 32'(a_e));
      end
    end
    if (!rst && q_done) begin
      if (q_sb.size() == 0) check("qdone_unexpected", 1, 0);
      else begin
        q_e = q_sb.pop_front();
        check("q_found", 32'(q_found), 32'(q_e.found));
        check("q_base",  32'(q_base),  32'(q_e.base));
        check("q_count", 32'(q_count), 32'(q_e.count));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; alloc_req = 0; commit = 0; abort = 0; wr_en = 0; q_req = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [2:0] m, input logic [2:0] n, input logic [8:0] exp);
    int k;
    bit seen;
    @(negedge clk);
    alloc_req = 1'b1; alloc_m = m; alloc_n = n;
    a_sb.push_back(exp);
    @(negedge clk);
    alloc_req = 1'b0;
    check("busy_ascan", 32'(busy), 1);
    k = 1; seen = 0;
    while (!seen && k < 60) begin
      if (addr_ready) seen = 1;
      else begin @(negedge clk); k++; end
    end
    check("grant_seen", 32'(seen), 1);
    if (seen) check("grant_latency", k - 1, NUM_SLOTS + 1);
    check("wr_err_after_grant", 32'(wr_err), 0);
  endtask

  task automatic do_query(input logic [2:0] m, input logic [2:0] n, input logic [2:0] idx,
                          input logic f, input logic [8:0] b, input logic [2:0] c);
    int k;
    bit seen;
    @(negedge clk);
    q_req = 1'b1; q_m = m; q_n = n; q_idx = idx;
    q_sb.push_back('{found: f, base: b, count: c});
    @(negedge clk);
    q_req = 1'b0;
    k = 1; seen = 0;
    while (!seen && k < 60) begin
      if (q_done) seen = 1;
      else begin @(negedge clk); k++; end
    end
    check("qdone_seen", 32'(seen), 1);
    if (seen) check("q_latency", k - 1, NUM_SLOTS + 1);
  endtask

  task automatic pulse(input bit c, input bit a);
    @(negedge clk);
    commit = c; abort = a;
    @(negedge clk);
    commit = 0; abort = 0;
  endtask

  task automatic write_word(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_word(input logic [8:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alloc_req = 0; alloc_m = 0; alloc_n = 0; commit = 0; abort = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; q_req = 0; q_m = 0; q_n = 0; q_idx = 0;

    // reset state
    do_reset();
    check("rst_addr_ready", 32'(addr_ready), 0);
    check("rst_base_addr",  32'(base_addr), 0);
    check("rst_q_done",     32'(q_done), 0);
    check("rst_q_found",    32'(q_found), 0);
    check("rst_q_base",     32'(q_base), 0);
    check("rst_q_count",    32'(q_count), 0);
    check("rst_busy",       32'(busy), 0);
    check("rst_wr_err",     32'(wr_err), 0);
    check("rst_rd_data",    rd_data, 0);

    // single 2x3 matrix, write, read-during-write, commit, lookup
    do_alloc(3'd2, 3'd3, 9'd0);
    for (int i = 0; i < 6; i++) write_word(9'(i), 32'hA000_0000 + i);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 9'd2; wr_data = 32'h0000_00D2; rd_addr = 9'd2;
    @(negedge clk);
    wr_en = 1'b0;
    check("rdw_old_data", rd_data, 32'hA000_0002);
    read_word(9'd2, rdv);
    check("rdw_new_data", rdv, 32'h0000_00D2);
    pulse(1, 0);
    do_query(3'd2, 3'd3, 3'd0, 1'b1, 9'd0, 3'd1);
    read_word(9'd5, rdv);
    check("read_addr5", rdv, 32'hA000_0005);

    // three 2x2 allocations: free, free, then oldest matching
    do_reset();
    do_alloc(3'd2, 3'd2, 9'd0);  pulse(1, 0);
    do_alloc(3'd2, 3'd2, 9'd25); pulse(1, 0);
    do_alloc(3'd2, 3'd2, 9'd0);  pulse(1, 0);
    do_query(3'd2, 3'd2, 3'd1, 1'b1, 9'd25, 3'd2);
    do_query(3'd2, 3'd2, 3'd2, 1'b0, 9'd0, 3'd2);

    // back-to-back allocation from FILL implies a commit
    do_reset();
    do_alloc(3'd3, 3'd3, 9'd0);
    do_alloc(3'd3, 3'd3, 9'd25);
    pulse(1, 0);
    do_query(3'd3, 3'd3, 3'd0, 1'b1, 9'd0, 3'd2);

    // abort, commit+abort together, commit outside FILL
    do_reset();
    do_alloc(3'd4, 3'd4, 9'd0);
    pulse(0, 1);
    do_query(3'd4, 3'd4, 3'd0, 1'b0, 9'd0, 3'd0);
    do_alloc(3'd4, 3'd4, 9'd0);
    pulse(1, 1);
    do_query(3'd4, 3'd4, 3'd0, 1'b0, 9'd0, 3'd0);
    pulse(1, 0);
    do_query(3'd4, 3'd4, 3'd0, 1'b0, 9'd0, 3'd0);

    // fill every slot with distinct dims, then evict the oldest
    do_reset();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      do_alloc(3'(1 + i % 5), 3'(1 + i / 5), 9'(i * 25));
      pulse(1, 0);
    end
    do_alloc(3'd5, 3'd5, 9'd0);
    pulse(1, 0);
    do_query(3'd1, 3'd1, 3'd0, 1'b0, 9'd0, 3'd0);
    do_query(3'd5, 3'd5, 3'd0, 1'b1, 9'd0, 3'd1);
    do_query(3'd2, 3'd1, 3'd0, 1'b1, 9'd25, 3'd1);

    // write outside the granted slot's m*n window
    do_reset();
    do_alloc(3'd2, 3'd2, 9'd0);  pulse(1, 0);
    do_alloc(3'd3, 3'd3, 9'd25);
    write_word(9'd29, 32'h0BAD_0029);
    pulse(1, 0);
    do_reset();
    do_alloc(3'd2, 3'd2, 9'd0);  pulse(1, 0);
    do_alloc(3'd2, 3'd2, 9'd25);
    write_word(9'd29, 32'h1234_5678);
    read_word(9'd29, rdv);
`ifdef MATSTORE_GUARD_EN
    check("guard_wr_err", 32'(wr_err), 1);
    check("guard_ram29", rdv, 32'h0BAD_0029);
`else
    check("noguard_wr_err", 32'(wr_err), 0);
    check("noguard_ram29", rdv, 32'h1234_5678);
`endif
    pulse(0, 1);
    do_alloc(3'd2, 3'd2, 9'd25);
    pulse(1, 0);

    repeat (3) @(negedge clk);
    check("sb_alloc_empty", a_sb.size(), 0);
    check("sb_query_empty", q_sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
